// File: rtl/sram_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : sram_test_sequencer
// Brief   : Writes an address-seeded pattern to the SRAM controller, reads it
//           back and reports pass/fail, error count and first failing word.
//           Define SRAM_TEST_INVERT_PASS_EN for a second, inverted-pattern pass.
// Revision: 1.0
// ============================================================================
module sram_test_sequencer #(
    parameter int                    ADDR_WIDTH     = 18,
    parameter int                    DATA_WIDTH     = 16,
    parameter int unsigned           ADDR_LAST      = 2**18-1,
    parameter logic [DATA_WIDTH-1:0] PATTERN        = 16'hAAAA,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           error_count,
    output logic [ADDR_WIDTH-1:0] fail_address,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_write,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_data_read,
    input  logic                  mem_ready
);

`ifdef SRAM_TEST_INVERT_PASS_EN
    localparam bit c_INVERT_EN = 1'b1;
`else
    localparam bit c_INVERT_EN = 1'b0;
`endif

    localparam int                    c_TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0]       c_TMO_LAST  = c_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_LAST = ADDR_WIDTH'(ADDR_LAST);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_W_REQ  = 4'd1,
        S_W_BUSY = 4'd2,
        S_W_DONE = 4'd3,
        S_R_REQ  = 4'd4,
        S_R_BUSY = 4'd5,
        S_R_DONE = 4'd6,
        S_CHECK  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inv_q, inv_d;
    logic [c_TW-1:0]       tmo_q, tmo_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           err_q, err_d;
    logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [DATA_WIDTH-1:0] w_addr_bits;
    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_last;
    logic                  w_wait_state;
    logic                  w_write_phase;

    if (ADDR_WIDTH >= DATA_WIDTH) begin : g_addr_trunc
        assign w_addr_bits = addr_q[DATA_WIDTH-1:0];
    end else begin : g_addr_ext
        assign w_addr_bits = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, addr_q};
    end

    assign w_expected    = PATTERN ^ w_addr_bits ^ {DATA_WIDTH{inv_q}};
    assign w_last        = (addr_q == c_ADDR_LAST);
    assign w_write_phase = (state_q == S_W_REQ) || (state_q == S_W_BUSY) || (state_q == S_W_DONE);
    assign w_wait_state  = w_write_phase || (state_q == S_R_REQ) ||
                           (state_q == S_R_BUSY) || (state_q == S_R_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            inv_q       <= 1'b0;
            tmo_q       <= '0;
            timeout_q   <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            inv_q       <= inv_d;
            tmo_q       <= tmo_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        inv_d       = inv_q;
        tmo_d       = tmo_q;
        timeout_d   = timeout_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_W_REQ;
                    addr_d      = '0;
                    inv_d       = 1'b0;
                    timeout_d   = 1'b0;
                    err_d       = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_W_REQ:  if (mem_ready)  state_d = S_W_BUSY;
            S_W_BUSY: if (!mem_ready) state_d = S_W_DONE;
            S_W_DONE: begin
                if (mem_ready) begin
                    if (w_last) begin
                        addr_d  = '0;
                        state_d = S_R_REQ;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_W_REQ;
                    end
                end
            end
            S_R_REQ:  if (mem_ready)  state_d = S_R_BUSY;
            S_R_BUSY: if (!mem_ready) state_d = S_R_DONE;
            S_R_DONE: begin
                if (mem_ready) begin
                    rdata_d = mem_data_read;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (rdata_q != w_expected) begin
                    if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    // A zero count means no earlier mismatch in this run
                    if (err_q == 16'd0) begin
                        fail_addr_d = addr_q;
                        fail_data_d = rdata_q;
                    end
                end
                if (w_last) begin
                    if (c_INVERT_EN && !inv_q) begin
                        inv_d   = 1'b1;
                        addr_d  = '0;
                        state_d = S_W_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_R_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Per-phase watchdog: restarts on every state change
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (w_wait_state) begin
            if (tmo_q == c_TMO_LAST) begin
                state_d   = S_DONE;
                timeout_d = 1'b1;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign pass           = done && !timeout_q && (err_q == 16'd0);
    assign timeout        = timeout_q;
    assign error_count    = err_q;
    assign fail_address   = fail_addr_q;
    assign fail_data      = fail_data_q;
    assign mem_address    = addr_q;
    assign mem_data_write = w_write_phase ? w_expected : '0;
    assign mem_write      = (state_q == S_W_REQ) && mem_ready;
    assign mem_read       = (state_q == S_R_REQ) && mem_ready;

endmodule
`default_nettype wire

// File: tb/tb_sram_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_test_sequencer
// Brief   : Scoreboard bench with a randomized-latency SRAM controller model.
// Revision: 1.0
// ============================================================================
module tb_sram_test_sequencer;
    localparam int          AW   = 18;
    localparam int          DW   = 16;
    localparam int          LAST = 3;
    localparam logic [15:0] PAT  = 16'hAAAA;
`ifdef SRAM_TEST_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, pass, timeout;
    logic [15:0]   error_count;
    logic [AW-1:0] fail_address, mem_address;
    logic [DW-1:0] fail_data, mem_data_write;
    logic          mem_write, mem_read;
    logic [DW-1:0] mem_data_read = '0;
    logic          mem_ready = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sram_test_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LAST(LAST),
        .PATTERN(PAT), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .error_count(error_count), .fail_address(fail_address), .fail_data(fail_data),
        .mem_address(mem_address), .mem_data_write(mem_data_write),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_data_read(mem_data_read), .mem_ready(mem_ready)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Controller model: ready drops for a random 1..3 cycles per accepted op
    logic        stall = 1'b0;
    logic [15:0] corrupt_mask = '0;
    logic [15:0] corrupt_xor = '0;
    logic [15:0] mem [0:15];
    int          bcnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            mem_ready <= 1'b1;
            bcnt      <= 0;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) mem_ready <= 1'b1;
        end else if (mem_ready && mem_write) begin
            mem[mem_address[3:0]] <= mem_data_write;
            if (!stall) begin
                mem_ready <= 1'b0;
                bcnt      <= $urandom_range(1, 3);
            end
        end else if (mem_ready && mem_read) begin
            mem_data_read <= corrupt_mask[mem_address[3:0]] ?
                             (mem[mem_address[3:0]] ^ corrupt_xor) : mem[mem_address[3:0]];
            mem_ready     <= 1'b0;
            bcnt          <= $urandom_range(1, 3);
        end
    end

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct packed {
        logic          to;
        logic          ps;
        logic [15:0]   ec;
        logic [AW-1:0] fa;
        logic [DW-1:0] fd;
    } res_t;

    txn_t exp_q[$];
    res_t res_q[$];

    function automatic logic [15:0] pattern_of(input int p, input int a);
        logic [15:0] v;
        v = PAT ^ 16'(a);
        return (p == 0) ? v : ~v;
    endfunction

    // Reference: full expected strobe sequence and final verdict for one run
    task automatic plan_run(input bit st, input logic [15:0] mask, input logic [15:0] cx);
        txn_t t;
        res_t r;
        int   errs;
        errs = 0;
        r    = '0;
        if (st) begin
            t.wr = 1'b1; t.addr = '0; t.data = PAT;
            exp_q.push_back(t);
            r.to = 1'b1;
            res_q.push_back(r);
            return;
        end
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a <= LAST; a++) begin
                t.wr = 1'b1; t.addr = AW'(a); t.data = pattern_of(p, a);
                exp_q.push_back(t);
            end
            for (int a = 0; a <= LAST; a++) begin
                t.wr = 1'b0; t.addr = AW'(a); t.data = '0;
                exp_q.push_back(t);
                if (mask[a]) begin
                    if (errs == 0) begin
                        r.fa = AW'(a);
                        r.fd = pattern_of(p, a) ^ cx;
                    end
                    errs++;
                end
            end
        end
        r.ec = (errs > 65535) ? 16'hFFFF : 16'(errs);
        r.ps = (errs == 0);
        res_q.push_back(r);
    endtask

    // Monitor: pops expectations whenever the DUT strobes or completes
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            chk("busy_done_exclusive", busy & done, 0);
            if (mem_write || mem_read) begin
                chk("strobe_expected", exp_q.size() != 0, 1);
                chk("strobe_when_ready", mem_ready, 1);
                chk("single_strobe", mem_write & mem_read, 0);
                if (exp_q.size() != 0) begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("strobe_type", mem_write, t.wr);
                    chk("strobe_addr", mem_address, t.addr);
                    if (t.wr) chk("write_data", mem_data_write, t.data);
                end
            end
            if (done && !done_prev) begin
                chk("result_expected", res_q.size() != 0, 1);
                chk("strobes_outstanding", exp_q.size(), 0);
                if (res_q.size() != 0) begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("pass", pass, r.ps);
                    chk("timeout", timeout, r.to);
                    chk("error_count", error_count, r.ec);
                    chk("fail_address", fail_address, r.fa);
                    chk("fail_data", fail_data, r.fd);
                end
            end
        end
        done_prev <= done;
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_error_count"}, error_count, 0);
        chk({tag, "_fail_address"}, fail_address, 0);
        chk({tag, "_fail_data"}, fail_data, 0);
        chk({tag, "_mem_address"}, mem_address, 0);
        chk({tag, "_mem_data_write"}, mem_data_write, 0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_read"}, mem_read, 0);
    endtask

    task automatic run(input bit st, input logic [15:0] mask, input logic [15:0] cx, input bit poke);
        int cyc;
        stall        = st;
        corrupt_mask = mask;
        corrupt_xor  = cx;
        plan_run(st, mask, cx);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_cleared", done, 0);
        chk("error_count_cleared", error_count, 0);
        chk("timeout_cleared", timeout, 0);
        cyc = 0;
        while (!done && cyc < 2000) begin
            start = (poke && (cyc == 7 || cyc == 15));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("run_completed", done, 1);
        if (st) chk("timeout_latency_in_range", (cyc >= 250) && (cyc <= 270), 1);
        repeat (12) @(negedge clk);
        chk("done_sticky", done, 1);
        stall = 1'b0;
    endtask

    initial begin
        logic [15:0] m, x;
        int          k;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        run(1'b0, 16'h0000, 16'h0000, 1'b0);
        run(1'b0, 16'h0004, 16'hAAA8, 1'b0);
        for (int i = 0; i < 4; i++) begin
            m = 16'($urandom_range(0, 15));
            x = 16'($urandom_range(1, 65535));
            run(1'b0, m, x, 1'b1);
        end
        run(1'b1, 16'h0000, 16'h0000, 1'b0);

        plan_run(1'b0, 16'h0000, 16'h0000);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!mem_read && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("read_phase_reached", mem_read, 1);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        chk_all_zero("reset_in_read");
        exp_q.delete();
        res_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run(1'b0, 16'h0000, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
